// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// The wait-state encodings are only consumed when DSRAM_WAIT_EN is defined.
package data_sram_resp_pkg;

   typedef enum logic [1:0] {
      DSRAM_IDLE = 2'd0,
      DSRAM_BUSY = 2'd1,
      DSRAM_DONE = 2'd2
   } dsram_state_e;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam int DATA_W = 32;
   localparam int WEN_W  = 4;
   localparam int CNT_W  = 4;

endpackage

// File: rtl/data_sram_resp_wait_fsm.sv
// Wait-state controller for the data SRAM: holds a request for WAIT_CYCLES
// extra cycles and stalls the pipeline. Only instantiated under DSRAM_WAIT_EN.
module dsram_wait_fsm
   import data_sram_resp_pkg::*;
#(
   parameter int IDX_W       = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_en,
   input  logic [WEN_W-1:0]  req_wen,
   input  logic [IDX_W-1:0]  req_idx,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              acc_en,
   output logic [WEN_W-1:0]  acc_wen,
   output logic [IDX_W-1:0]  acc_idx,
   output logic [DATA_W-1:0] acc_wdata,
   output logic              stallreq
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   dsram_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WEN_W-1:0]  wen_q, wen_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wen_d     = wen_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      acc_en    = 1'b0;
      acc_wen   = wen_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      stallreq  = NO_STOP;
      case (state_q)
         DSRAM_IDLE: begin
            if (req_en) begin
               if (WAIT_CYCLES > 0) begin
                  stallreq = STOP;
                  wen_d    = req_wen;
                  idx_d    = req_idx;
                  wdata_d  = req_wdata;
                  cnt_d    = WAIT_INIT;
                  state_d  = DSRAM_BUSY;
               end else begin
                  acc_en    = 1'b1;
                  acc_wen   = req_wen;
                  acc_idx   = req_idx;
                  acc_wdata = req_wdata;
               end
            end
         end
         DSRAM_BUSY: begin
            stallreq = STOP;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               acc_en  = 1'b1;
               state_d = DSRAM_DONE;
            end
         end
         // The held request was just served, so a still-high en is not a new one.
         DSRAM_DONE: state_d = DSRAM_IDLE;
         default:    state_d = DSRAM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DSRAM_IDLE;
         cnt_q   <= '0;
         wen_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: rtl/data_sram_resp.sv
// Word-organised, byte-writable data SRAM with registered read data.
// Define DSRAM_WAIT_EN to add the wait-state controller and stall request.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_sram_en,
   input  logic [WEN_W-1:0]  data_sram_wen,
   input  logic [31:0]       data_sram_addr,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic [DATA_W-1:0] data_sram_rdata,
   output logic              stallreq
);

   localparam int DEPTH = 1 << ADDR_W;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_sram_resp: WAIT_CYCLES must be in 0..15");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] word_idx;
   logic              acc_en;
   logic [WEN_W-1:0]  acc_wen;
   logic [ADDR_W-1:0] acc_idx;
   logic [DATA_W-1:0] acc_wdata;
   logic              do_access;
   logic              unused_addr_bits;

   // Upper and byte-offset address bits are ignored, so addresses alias modulo depth.
   assign word_idx         = data_sram_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DSRAM_WAIT_EN
   dsram_wait_fsm #(
      .IDX_W       (ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_fsm (
      .clk       (clk),
      .rst       (rst),
      .req_en    (data_sram_en),
      .req_wen   (data_sram_wen),
      .req_idx   (word_idx),
      .req_wdata (data_sram_wdata),
      .acc_en    (acc_en),
      .acc_wen   (acc_wen),
      .acc_idx   (acc_idx),
      .acc_wdata (acc_wdata),
      .stallreq  (stallreq)
   );
`else
   assign acc_en    = data_sram_en;
   assign acc_wen   = data_sram_wen;
   assign acc_idx   = word_idx;
   assign acc_wdata = data_sram_wdata;
   assign stallreq  = NO_STOP;
`endif

   assign do_access = acc_en && !rst;

   always_comb begin
      rdata_d = rdata_q;
      if (do_access && acc_wen == '0) begin
         rdata_d = mem[acc_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // The array is deliberately left out of reset; writes touch only enabled lanes.
   always_ff @(posedge clk) begin
      if (do_access) begin
         for (int i = 0; i < WEN_W; i++) begin
            if (acc_wen[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp; wait-state steps are included when
// DSRAM_WAIT_EN is defined, otherwise stallreq is checked to stay low.
module tb_data_sram_resp;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stallreq;

   int pass_count  = 0;
   int total_count = 0;
   bit in_done     = 1'b0;

   always #5 clk = ~clk;

   data_sram_resp #(
      .ADDR_W      (12),
      .WAIT_CYCLES (W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .stallreq        (stallreq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic e, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d);
      en    = e;
      wen   = w;
      addr  = a;
      wdata = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Leaves the bench in the cycle where rdata for this access is valid.
   task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      if (in_done) begin
         applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
         step();
         in_done = 1'b0;
      end
      applyStimulus(1'b1, w, a, d);
      step();
`ifdef DSRAM_WAIT_EN
      repeat (W) step();
      in_done = 1'b1;
`endif
      applyStimulus(1'b0, 4'h0, a, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      step();
      step();
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_stallreq", {31'h0, stallreq}, 32'h0);
      rst = 1'b0;

      access(4'hF, 32'h100, 32'hDEADBEEF);
      checkOutput("write_no_writethrough", rdata, 32'h0);
      access(4'h0, 32'h100, 32'h0);
      checkOutput("raw_full_word", rdata, 32'hDEADBEEF);

      access(4'hF, 32'h40, 32'h11223344);
      access(4'b0101, 32'h40, 32'hAABBCCDD);
      access(4'h0, 32'h40, 32'h0);
      checkOutput("byte_lanes", rdata, 32'h11BB33DD);

      access(4'hF, 32'h4, 32'h12345678);
      access(4'h0, 32'h4, 32'h0);
      checkOutput("read_0x4", rdata, 32'h12345678);
      access(4'h0, 32'h100, 32'h0);
      checkOutput("read_back_0x100", rdata, 32'hDEADBEEF);
      access(4'h0, 32'h4004, 32'h0);
      checkOutput("alias_0x4004", rdata, 32'h12345678);
      access(4'h0, 32'h40, 32'h0);
      checkOutput("read_back_0x40", rdata, 32'h11BB33DD);
      access(4'h0, 32'h7, 32'h0);
      checkOutput("byte_offset_ignored", rdata, 32'h12345678);

      access(4'hF, 32'h8008, 32'hCAFEF00D);
      access(4'h0, 32'h8, 32'h0);
      checkOutput("alias_write_high_bits", rdata, 32'hCAFEF00D);

      applyStimulus(1'b0, 4'h0, 32'h100, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         in_done = 1'b0;
         checkOutput($sformatf("hold_en0_%0d", i), rdata, 32'hCAFEF00D);
      end

`ifndef DSRAM_WAIT_EN
      applyStimulus(1'b1, 4'h0, 32'h100, 32'h0);
      #1;
      checkOutput("stallreq_tied_low", {31'h0, stallreq}, 32'h0);
      step();
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      step();
`endif

      // Reset and a write request on the same edge: reset wins.
      rst = 1'b1;
      applyStimulus(1'b1, 4'hF, 32'h100, 32'h55555555);
      step();
      checkOutput("rst_clears_rdata", rdata, 32'h0);
      rst = 1'b0;
      in_done = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      access(4'h0, 32'h100, 32'h0);
      checkOutput("rst_blocks_write", rdata, 32'hDEADBEEF);

`ifdef DSRAM_WAIT_EN
      access(4'hF, 32'h300, 32'h0A0B0C0D);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      step();
      in_done = 1'b0;

      applyStimulus(1'b1, 4'h0, 32'h300, 32'h0);
      #1;
      checkOutput("wait_stall_t0", {31'h0, stallreq}, 32'h1);
      step();
      checkOutput("wait_stall_t1", {31'h0, stallreq}, 32'h1);
      step();
      checkOutput("wait_stall_t2", {31'h0, stallreq}, 32'h1);
      checkOutput("wait_no_early_read", rdata, 32'hDEADBEEF);
      step();
      checkOutput("wait_done_stall", {31'h0, stallreq}, 32'h0);
      checkOutput("wait_done_rdata", rdata, 32'h0A0B0C0D);
      applyStimulus(1'b1, 4'hF, 32'h300, 32'hFFFFFFFF);
      step();
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checkOutput("wait_idle_after_done", {31'h0, stallreq}, 32'h0);
      access(4'h0, 32'h300, 32'h0);
      checkOutput("done_ignores_en", rdata, 32'h0A0B0C0D);

      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      step();
      in_done = 1'b0;
      applyStimulus(1'b1, 4'hF, 32'h300, 32'h12121212);
      step();
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      step();
      rst = 1'b0;
      #1;
      checkOutput("busy_rst_stall", {31'h0, stallreq}, 32'h0);
      checkOutput("busy_rst_rdata", rdata, 32'h0);
      step();
      checkOutput("busy_rst_idle", {31'h0, stallreq}, 32'h0);
      access(4'h0, 32'h300, 32'h0);
      checkOutput("busy_rst_no_write", rdata, 32'h0A0B0C0D);
`endif

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side SRAM responder for the 5-stage CPU. It serves the data port that EX drives (en, byte write enables, address, write data) and returns read data, which MEM consumes one cycle later. It is a word-organised, byte-writable synchronous RAM with registered read data. A compile-time option adds a wait-state controller that raises a stall request toward the pipeline controller, so slower memories can be modelled.

## Interface
Parameters:
- ADDR_W, 12, word-address bits; depth = 2^ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, extra access latency. Only used when DSRAM_WAIT_EN is defined. Legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- data_sram_en  in  1  access request.
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]. All zero means read.
- data_sram_addr  in  32  byte address. Word index is addr[ADDR_W+1:2]. addr[1:0] and higher bits are ignored, so addresses alias modulo depth.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  registered read data.
- stallreq  out  1  stall request to the pipeline controller. Tied 0 without DSRAM_WAIT_EN.

## Operation
- Access types:
  - Read: en=1 and wen=0000. rdata is loaded with mem[word] at the access edge.
  - Write: en=1 and wen!=0. Only enabled byte lanes are updated. rdata is unchanged; there is no write-through.
  - en=0: no access; rdata holds.
- rdata holds its last read value until the next read access edge.
- Read-after-write to the same word on consecutive edges returns the new data. The RAM is written at edge N and the read samples at edge N+1.
- Memory array is not cleared by rst. Contents are X until written or preloaded by the bench.
- Wait-state FSM (DSRAM_WAIT_EN only). States:
  - IDLE:
    - stallreq = en, combinational.
    - If en=1 and WAIT_CYCLES>0: latch wen, word index and wdata; load cnt with WAIT_CYCLES; go to BUSY. No access is made this edge.
    - If en=1 and WAIT_CYCLES==0: access immediately, as in the zero-wait path; stallreq=0.
  - BUSY:
    - stallreq=1.
    - cnt decrements each edge.
    - At the edge where cnt==1, perform the latched access and go to DONE.
    - Live port inputs are ignored.
  - DONE:
    - stallreq=0; en is ignored, because the held request is the one just served.
    - Next state is IDLE.
- Total stall cycles per access = WAIT_CYCLES+1. rdata is valid from the DONE cycle and holds while the instruction sits in MEM.
- 4-bit cnt; a value of 0 in BUSY is unreachable.

## Timing
- Reset values:
  - rdata = 32'h0.
  - stallreq = 0.
  - state = IDLE, cnt = 0, latched request cleared.
- Zero-wait latency:
  - Request at cycle t; rdata is valid in cycle t+1, which is the MEM cycle of that instruction.
  - Back-to-back accesses every cycle; throughput 1/cycle.
- Wait mode with WAIT_CYCLES=W>0:
  - Request at t; stallreq=1 in cycles t..t+W.
  - Access at the end of t+W; DONE in t+W+1; next IDLE at t+W+2.
- Reset mid-operation: state returns to IDLE, the latched request is discarded, no write is performed, and rdata goes to 0.
- Simultaneous rst and en: rst wins and no access is made.

## Configuration
- DSRAM_WAIT_EN:
  - Defined: wait-state FSM, cnt and latch registers are compiled in; stallreq is driven as above.
  - Undefined: pure zero-wait RAM; stallreq is constant 0 and WAIT_CYCLES is ignored.

## Structure
- Shared package/defines.vh entries:
  - DSRAM_IDLE, DSRAM_BUSY and DSRAM_DONE state encodings (2 bits).
  - The existing Stop/NoStop constants, used for stallreq polarity.
- Sub-module dsram_wait_fsm: owns the state register, cnt, latched request, and the mux that selects between latched and live request. It is instantiated only under DSRAM_WAIT_EN.
- RAM array and rdata register stay in the top.

## Test plan
- Reset: assert rst 2 cycles -> rdata=0, stallreq=0.
- Full-word write then read: write 0xDEADBEEF to 0x100 with wen=1111; next cycle read 0x100 -> rdata=0xDEADBEEF one cycle after the read request.
- Byte lanes: preload 0x11223344 at 0x40, write wen=0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
- Aliasing and hold:
  - Read 0x4 with ADDR_W=12, then read 0x4004 -> same data.
  - en=0 for 3 cycles -> rdata unchanged.
- Wait mode, W=2, read at t: stallreq=1 in t..t+2 and 0 at t+3; rdata valid at t+3; en held high in t+3 causes no second access.
- Reset mid-BUSY on a write: rst asserted at t+1 -> target word is unchanged, state is IDLE, stallreq=0 next cycle.
